// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 init/stream sequencer.
package ili9341_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } opcode_e;

  typedef struct packed {
    opcode_e     op;
    logic [15:0] payload;
  } rom_entry_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int unsigned INIT_ROM_DEPTH = 11;
  localparam int unsigned ROM_ADDR_W     = $clog2(INIT_ROM_DEPTH);

  typedef enum logic [3:0] {
    StHwReset  = 4'd0,
    StHwWake   = 4'd1,
    StFetch    = 4'd2,
    StDelay    = 4'd3,
    StIssue    = 4'd4,
    StWait     = 4'd5,
    StFrameCmd = 4'd6,
    StPixel    = 4'd7
  } state_e;

  function automatic rom_entry_t rom_entry(input opcode_e op, input logic [15:0] payload);
    rom_entry_t e;
    e.op      = op;
    e.payload = payload;
    return e;
  endfunction

endpackage

// File: rtl/spi_types.sv
// Transaction modes understood by the SPI controller downstream of the sequencer.
package spi_types;

  typedef enum logic [1:0] {
    WRITE_8  = 2'd0,
    WRITE_16 = 2'd1,
    READ_8   = 2'd2,
    READ_16  = 2'd3
  } spi_transaction_t;

endpackage

// File: rtl/ili9341_init_rom.sv
// Fixed ILI9341 power-up sequence; addresses past the table read as OP_END.
module ili9341_init_rom
  import ili9341_pkg::*;
(
  input  logic [ROM_ADDR_W-1:0] addr,
  output rom_entry_t            entry
);

  always_comb begin
    entry = rom_entry(OP_END, 16'h0000);
    case (addr)
      4'd0:    entry = rom_entry(OP_CMD,   {8'h00, CMD_SWRESET});
      4'd1:    entry = rom_entry(OP_DELAY, 16'd5);
      4'd2:    entry = rom_entry(OP_CMD,   {8'h00, CMD_SLPOUT});
      4'd3:    entry = rom_entry(OP_DELAY, 16'd120);
      4'd4:    entry = rom_entry(OP_CMD,   {8'h00, CMD_COLMOD});
      4'd5:    entry = rom_entry(OP_DATA,  16'h0055);
      4'd6:    entry = rom_entry(OP_CMD,   {8'h00, CMD_MADCTL});
      4'd7:    entry = rom_entry(OP_DATA,  16'h0048);
      4'd8:    entry = rom_entry(OP_CMD,   {8'h00, CMD_DISPON});
      4'd9:    entry = rom_entry(OP_DELAY, 16'd20);
      default: entry = rom_entry(OP_END,   16'h0000);
    endcase
  end

endmodule

// File: rtl/ili9341_stream_sequencer.sv
// Drives ILI9341 reset, plays the init ROM into the SPI controller, then streams
// RGB565 frames, each preceded by a RAMWR command.
module ili9341_stream_sequencer
  import spi_types::*;
  import ili9341_pkg::*;
#(
  parameter int unsigned WIDTH             = 240,
  parameter int unsigned HEIGHT            = 320,
  parameter int unsigned RESET_CYCLES      = 12000,
  parameter int unsigned WAKE_CYCLES       = 1440000,
  parameter int unsigned DELAY_UNIT_CYCLES = 12000
) (
  input  logic             clk,
  input  logic             rst_b,
  output spi_transaction_t spi_mode,
  output logic             spi_i_valid,
  output logic [15:0]      spi_i_data,
  input  logic             spi_i_ready,
  output logic             display_dc,
  output logic             display_rstb,
  input  logic             px_valid,
  output logic             px_ready,
  input  logic [15:0]      px_data,
  output logic             init_done,
  output logic             frame_start
);

  localparam int unsigned CntMax    = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
  localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned UnitW     = (DELAY_UNIT_CYCLES > 1) ? $clog2(DELAY_UNIT_CYCLES) : 1;
  localparam int unsigned NumPixels = WIDTH * HEIGHT;
  localparam int unsigned PixW      = (NumPixels > 1) ? $clog2(NumPixels) : 1;

  localparam logic [CntW-1:0]       CntOne  = CntW'(1);
  localparam logic [UnitW-1:0]      UnitOne = UnitW'(1);
  localparam logic [PixW-1:0]       PixOne  = PixW'(1);
  localparam logic [ROM_ADDR_W-1:0] AddrOne = ROM_ADDR_W'(1);

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [UnitW-1:0]        unit_q, unit_d;
  logic [15:0]             units_q, units_d;
  logic [PixW-1:0]         pix_q, pix_d;
  logic [ROM_ADDR_W-1:0]   addr_q, addr_d;
  logic                    seen_low_q, seen_low_d;
  logic                    is_ramwr_q, is_ramwr_d;
  logic                    valid_q, valid_d;
  logic [15:0]             data_q, data_d;
  spi_transaction_t        mode_q, mode_d;
  logic                    dc_q, dc_d;
  logic                    rstb_q, rstb_d;
  logic                    init_done_q, init_done_d;
  logic                    frame_start_q, frame_start_d;
  rom_entry_t              rom_q;

  ili9341_init_rom u_rom (
    .addr  (addr_q),
    .entry (rom_q)
  );

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    cnt_d         = cnt_q;
    unit_d        = unit_q;
    units_d       = units_q;
    pix_d         = pix_q;
    addr_d        = addr_q;
    seen_low_d    = seen_low_q;
    is_ramwr_d    = is_ramwr_q;
    valid_d       = valid_q;
    data_d        = data_q;
    mode_d        = mode_q;
    dc_d          = dc_q;
    rstb_d        = rstb_q;
    init_done_d   = init_done_q;
    frame_start_d = 1'b0;

    unique case (state_q)
      StHwReset: begin
        if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          rstb_d  = 1'b1;
          state_d = StHwWake;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StHwWake: begin
        if (cnt_q == CntW'(WAKE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StFetch: begin
        unique case (rom_q.op)
          OP_CMD, OP_DATA: begin
            dc_d       = (rom_q.op == OP_DATA);
            mode_d     = WRITE_8;
            data_d     = {8'h00, rom_q.payload[7:0]};
            valid_d    = 1'b1;
            ret_d      = StFetch;
            is_ramwr_d = 1'b0;
            state_d    = StIssue;
          end
          OP_DELAY: begin
            if (rom_q.payload == 16'd0) begin
              addr_d = addr_q + AddrOne;
            end else begin
              units_d = rom_q.payload;
              unit_d  = '0;
              state_d = StDelay;
            end
          end
          OP_END: begin
            init_done_d = 1'b1;
            state_d     = StFrameCmd;
          end
        endcase
      end

      // Unit counter nested inside a payload counter: payload*unit cycles, no multiplier.
      StDelay: begin
        if (unit_q == UnitW'(DELAY_UNIT_CYCLES - 1)) begin
          unit_d = '0;
          if (units_q == 16'd1) begin
            addr_d  = addr_q + AddrOne;
            state_d = StFetch;
          end else begin
            units_d = units_q - 16'd1;
          end
        end else begin
          unit_d = unit_q + UnitOne;
        end
      end

      StIssue: begin
        if (valid_q && spi_i_ready) begin
          valid_d       = 1'b0;
          seen_low_d    = 1'b0;
          frame_start_d = is_ramwr_q;
          state_d       = StWait;
        end
      end

      // Ready stays high through the accepting edge, so wait for a low-then-high cycle.
      StWait: begin
        if (!spi_i_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = ret_q;
          if (ret_q == StFetch) addr_d = addr_q + AddrOne;
        end
      end

      StFrameCmd: begin
        dc_d       = 1'b0;
        mode_d     = WRITE_8;
        data_d     = {8'h00, CMD_RAMWR};
        valid_d    = 1'b1;
        ret_d      = StPixel;
        pix_d      = '0;
        is_ramwr_d = 1'b1;
        state_d    = StIssue;
      end

      StPixel: begin
        if (px_valid) begin
          data_d     = px_data;
          dc_d       = 1'b1;
          mode_d     = WRITE_16;
          valid_d    = 1'b1;
          is_ramwr_d = 1'b0;
          state_d    = StIssue;
          if (pix_q == PixW'(NumPixels - 1)) begin
            pix_d = '0;
            ret_d = StFrameCmd;
          end else begin
            pix_d = pix_q + PixOne;
            ret_d = StPixel;
          end
        end
      end

      default: begin
        state_d     = StHwReset;
        ret_d       = StHwReset;
        cnt_d       = '0;
        unit_d      = '0;
        units_d     = '0;
        pix_d       = '0;
        addr_d      = '0;
        seen_low_d  = 1'b0;
        is_ramwr_d  = 1'b0;
        valid_d     = 1'b0;
        data_d      = '0;
        mode_d      = WRITE_8;
        dc_d        = 1'b0;
        rstb_d      = 1'b0;
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= StHwReset;
      ret_q         <= StHwReset;
      cnt_q         <= '0;
      unit_q        <= '0;
      units_q       <= '0;
      pix_q         <= '0;
      addr_q        <= '0;
      seen_low_q    <= 1'b0;
      is_ramwr_q    <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      mode_q        <= WRITE_8;
      dc_q          <= 1'b0;
      rstb_q        <= 1'b0;
      init_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      cnt_q         <= cnt_d;
      unit_q        <= unit_d;
      units_q       <= units_d;
      pix_q         <= pix_d;
      addr_q        <= addr_d;
      seen_low_q    <= seen_low_d;
      is_ramwr_q    <= is_ramwr_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      dc_q          <= dc_d;
      rstb_q        <= rstb_d;
      init_done_q   <= init_done_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign spi_mode     = mode_q;
  assign spi_i_valid  = valid_q;
  assign spi_i_data   = data_q;
  assign display_dc   = dc_q;
  assign display_rstb = rstb_q;
  assign init_done    = init_done_q;
  assign frame_start  = frame_start_q;
  assign px_ready     = (state_q == StPixel);

endmodule

// File: tb/tb_ili9341_stream_sequencer.sv
// Bench for ili9341_stream_sequencer with a small SPI controller model and word scoreboard.
module tb_ili9341_stream_sequencer;
  import spi_types::*;

  typedef struct {
    logic [15:0]      data;
    spi_transaction_t mode;
    logic             dc;
    int               cyc;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  spi_transaction_t spi_mode;
  logic             spi_i_valid;
  logic [15:0]      spi_i_data;
  logic             spi_i_ready = 1'b1;
  logic             display_dc;
  logic             display_rstb;
  logic             px_valid = 1'b0;
  logic             px_ready;
  logic [15:0]      px_data = 16'h0000;
  logic             init_done;
  logic             frame_start;

  int    tests = 0;
  int    fails = 0;
  int    cycle = 0;
  int    busy = 0;
  int    gap = 2;
  bit    hold = 1'b0;
  int    fs_count = 0;
  int    fs_cyc = 0;
  word_t act_q[$];
  word_t exp_q[$];

  ili9341_stream_sequencer #(
    .WIDTH             (2),
    .HEIGHT            (2),
    .RESET_CYCLES      (4),
    .WAKE_CYCLES       (6),
    .DELAY_UNIT_CYCLES (3)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .spi_mode     (spi_mode),
    .spi_i_valid  (spi_i_valid),
    .spi_i_data   (spi_i_data),
    .spi_i_ready  (spi_i_ready),
    .display_dc   (display_dc),
    .display_rstb (display_rstb),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_data      (px_data),
    .init_done    (init_done),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Controller model: records each accepted word, drops ready after acceptance for `gap` cycles.
  always @(posedge clk) begin
    word_t w;
    cycle++;
    if (!rst_b) begin
      busy = 0;
    end else if (spi_i_valid && spi_i_ready) begin
      w.data = spi_i_data;
      w.mode = spi_mode;
      w.dc   = display_dc;
      w.cyc  = cycle;
      act_q.push_back(w);
      busy = gap;
    end else if (busy > 0) begin
      busy--;
    end
    #1 spi_i_ready = (busy == 0) && !hold;
  end

  always @(negedge clk) begin
    if (frame_start) begin
      fs_count++;
      fs_cyc = cycle;
    end
  end

  function automatic word_t mk(input logic [15:0] d, input spi_transaction_t m, input logic dc);
    word_t w;
    w.data = d;
    w.mode = m;
    w.dc   = dc;
    w.cyc  = 0;
    return w;
  endfunction

  task automatic wait_act(input int n, output bit ok);
    int k = 0;
    while (act_q.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #2;
    ok = (act_q.size() >= n);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    int  n = 0;
    bit  ok = 1'b0;
    @(negedge clk);
    px_valid = 1'b1;
    px_data  = d;
    while (!ok && n < 500) begin
      ok = px_ready;
      @(posedge clk);
      n++;
    end
    #1 px_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL px_handshake: px_ready never seen for pixel %h", d);
    end
  endtask

  // Releases reset and checks the hardware-reset/wake timing up to the first SPI word.
  task automatic test_release;
    int n;
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (display_rstb !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL rstb_low_cycles: got %0d, expected 4", n);
    end
    n = 0;
    while (spi_i_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n < 6 || n > 7) begin
      fails++;
      $display("FAIL wake_to_first_valid: got %0d cycles, expected 6..7", n);
    end
    tests++;
    if (spi_i_data !== 16'h0001 || display_dc !== 1'b0 || spi_mode !== WRITE_8) begin
      fails++;
      $display("FAIL first_word: data=%h dc=%b mode=%0d, expected 0001/0/WRITE_8",
               spi_i_data, display_dc, spi_mode);
    end
    exp_q.push_back(mk(16'h0001, WRITE_8, 1'b0));
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (display_rstb !== 1'b0 || display_dc !== 1'b0 || spi_i_valid !== 1'b0 ||
        spi_i_data !== 16'h0000 || spi_mode !== WRITE_8 || init_done !== 1'b0 ||
        frame_start !== 1'b0 || px_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rstb=%b dc=%b v=%b d=%h m=%0d id=%b fs=%b pr=%b, expected all 0/WRITE_8",
               display_rstb, display_dc, spi_i_valid, spi_i_data, spi_mode, init_done,
               frame_start, px_ready);
    end
    test_release();
  endtask

  task automatic test_init;
    logic [7:0] cmds[7] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29};
    logic       dcs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int         cyc[7];
    bit         ok;
    int         n;
    for (int i = 1; i < 7; i++) exp_q.push_back(mk({8'h00, cmds[i]}, WRITE_8, dcs[i]));
    for (int i = 0; i < 7; i++) begin
      word_t a;
      word_t e;
      wait_act(1, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL init_word_timeout: word %0d never accepted, expected %h", i, cmds[i]);
        return;
      end
      a = act_q.pop_front();
      e = exp_q.pop_front();
      cyc[i] = a.cyc;
      if (a.data !== e.data || a.mode !== e.mode || a.dc !== e.dc) begin
        fails++;
        $display("FAIL init_word_%0d: got %h/%0d/dc%b, expected %h/%0d/dc%b",
                 i, a.data, a.mode, a.dc, e.data, e.mode, e.dc);
      end
    end
    tests++;
    if (cyc[1] - cyc[0] < 15) begin
      fails++;
      $display("FAIL gap_swreset: got %0d, expected >=15", cyc[1] - cyc[0]);
    end
    tests++;
    if (cyc[2] - cyc[1] < 360) begin
      fails++;
      $display("FAIL gap_slpout: got %0d, expected >=360", cyc[2] - cyc[1]);
    end
    tests++;
    if (init_done !== 1'b0) begin
      fails++;
      $display("FAIL init_done_early: got %b right after DISPON, expected 0", init_done);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (init_done !== 1'b1 || cycle - cyc[6] < 60) begin
      fails++;
      $display("FAIL init_done_delay: init_done=%b after %0d cycles, expected 1 after >=60",
               init_done, cycle - cyc[6]);
    end
  endtask

  task automatic test_frame;
    logic [15:0] pix[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    word_t       a;
    word_t       e;
    bit          ok;
    int          ramwr_cyc;
    exp_q.push_back(mk(16'h002C, WRITE_8, 1'b0));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(pix[i], WRITE_16, 1'b1));
      send_pixel(pix[i]);
    end
    exp_q.push_back(mk(16'h002C, WRITE_8, 1'b0));
    for (int i = 0; i < 6; i++) begin
      wait_act(1, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL frame_word_timeout: word %0d never accepted", i);
        return;
      end
      a = act_q.pop_front();
      e = exp_q.pop_front();
      if (a.data !== e.data || a.mode !== e.mode || a.dc !== e.dc) begin
        fails++;
        $display("FAIL frame_word_%0d: got %h/%0d/dc%b, expected %h/%0d/dc%b",
                 i, a.data, a.mode, a.dc, e.data, e.mode, e.dc);
      end
      if (i == 0 || i == 5) ramwr_cyc = a.cyc;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (fs_count != 2) begin
      fails++;
      $display("FAIL frame_start_count: got %0d pulses, expected 2", fs_count);
    end
    tests++;
    if (fs_cyc != ramwr_cyc) begin
      fails++;
      $display("FAIL frame_start_timing: pulse in cycle %0d, expected %0d", fs_cyc, ramwr_cyc);
    end
  endtask

  task automatic test_idle;
    int n = 0;
    while (px_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests++;
      if (px_ready !== 1'b1 || spi_i_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle_%0d: px_ready=%b spi_i_valid=%b, expected 1/0",
                 i, px_ready, spi_i_valid);
      end
    end
  endtask

  task automatic test_issue_hold;
    logic [15:0]      d0;
    spi_transaction_t m0;
    logic             dc0;
    int               sz0;
    int               n;
    bit               ok;
    word_t            a;
    word_t            e;
    @(negedge clk);
    hold        = 1'b1;
    spi_i_ready = 1'b0;
    exp_q.push_back(mk(16'h1234, WRITE_16, 1'b1));
    send_pixel(16'h1234);
    n = 0;
    while (spi_i_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    d0  = spi_i_data;
    m0  = spi_mode;
    dc0 = display_dc;
    sz0 = act_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (spi_i_valid !== 1'b1 || spi_i_data !== 16'h1234 || spi_i_data !== d0 ||
          spi_mode !== m0 || display_dc !== dc0) begin
        fails++;
        $display("FAIL hold_stable_%0d: v=%b d=%h m=%0d dc=%b, expected 1/1234/%0d/%b",
                 i, spi_i_valid, spi_i_data, spi_mode, display_dc, m0, dc0);
      end
    end
    tests++;
    if (act_q.size() != sz0) begin
      fails++;
      $display("FAIL hold_no_accept: %0d words accepted, expected %0d", act_q.size(), sz0);
    end
    hold = 1'b0;
    wait_act(1, ok);
    repeat (10) @(negedge clk);
    tests++;
    if (!ok || act_q.size() != 1) begin
      fails++;
      $display("FAIL hold_single_accept: %0d words accepted, expected 1", act_q.size());
    end else begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (a.data !== e.data || a.mode !== e.mode || a.dc !== e.dc) begin
        fails++;
        $display("FAIL hold_word: got %h/%0d/dc%b, expected %h/%0d/dc%b",
                 a.data, a.mode, a.dc, e.data, e.mode, e.dc);
      end
    end
  endtask

  task automatic test_mid_reset;
    int    n;
    bit    ok;
    word_t a;
    word_t e;
    @(negedge clk);
    hold        = 1'b1;
    spi_i_ready = 1'b0;
    send_pixel(16'hABCD);
    n = 0;
    while (spi_i_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3 rst_b = 1'b0;
    #1;
    tests++;
    if (display_rstb !== 1'b0 || display_dc !== 1'b0 || spi_i_valid !== 1'b0 ||
        spi_i_data !== 16'h0000 || spi_mode !== WRITE_8 || init_done !== 1'b0 ||
        frame_start !== 1'b0 || px_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: rstb=%b dc=%b v=%b d=%h m=%0d id=%b fs=%b pr=%b, expected all 0/WRITE_8",
               display_rstb, display_dc, spi_i_valid, spi_i_data, spi_mode, init_done,
               frame_start, px_ready);
    end
    hold = 1'b0;
    act_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    test_release();
    wait_act(1, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL restart_word: nothing accepted, expected 0001");
    end else begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      if (a.data !== e.data || a.mode !== e.mode || a.dc !== e.dc) begin
        fails++;
        $display("FAIL restart_word: got %h/%0d/dc%b, expected %h/%0d/dc%b",
                 a.data, a.mode, a.dc, e.data, e.mode, e.dc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_idle();
    test_issue_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
